mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
External memory bus controller directly downstream of the CPU core. It accepts single-byte read/write requests from the core over a valid/ready handshake and sequences them onto the external 16-bit address / 8-bit data bus with setup, strobe, wait-state and recovery phases. It returns read data on a one-cycle response pulse. It also supports bus hand-off to a bus master such as OAM DMA via hold_req/hold_ack.

Parameters:
WAIT_STATES, 1, extra strobe cycles per access; legal range 0..15 (4-bit counter)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  controller can accept request; combinational = (state==IDLE) && !hold_req
req_write  input  1  1=write, 0=read
req_addr  input  16  request address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle completion pulse (reads and writes)
rsp_rdata  output  8  read data, valid with rsp_valid on reads
memAddress  output  16  external address bus
memAddrOe  output  1  address bus drive enable
memDataOut  output  8  external write data
memDataIn  input  8  external read data
memDataOe  output  1  data bus drive enable (top level tristates memData)
memRd  output  1  read strobe, active high
memWr  output  1  write strobe, active high
hold_req  input  1  external master requests the bus
hold_ack  output  1  bus released to external master

Behaviour:
- Clocking and reset: single clock domain. rst_n low asynchronously forces every register to its reset value.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0x00, memAddress=0x0000, memAddrOe=1, memDataOut=0x00, memDataOe=0, memRd=0, memWr=0, hold_ack=0.
- States: IDLE, SETUP, STROBE, RECOVER, HOLD.
- IDLE:
  - hold_req=1 -> HOLD. Hold wins over a simultaneous req_valid; req_ready is 0, so the request is not accepted.
  - Otherwise req_valid=1 -> latch addr, wdata and write, then go to SETUP.
  - Outputs: memAddress keeps its last value; memRd=memWr=memDataOe=0.
- SETUP (1 cycle):
  - memAddress=latched addr.
  - memDataOut=latched wdata and memDataOe=1 for writes.
  - Strobe counter loaded with WAIT_STATES.
  - Next state: STROBE.
- STROBE (WAIT_STATES+1 cycles):
  - memRd (read) or memWr (write) held high; counter decrements each cycle.
  - On the cycle with counter==0, reads capture memDataIn into rsp_rdata at the closing edge, then go to RECOVER.
- RECOVER (1 cycle):
  - Strobes low; address and, for writes, memDataOe/memDataOut held for hold time.
  - rsp_valid=1 for exactly this cycle.
  - Next state: IDLE.
- Write responses: rsp_rdata keeps its previous value.
- HOLD:
  - memAddrOe=0, memDataOe=0, memRd=memWr=0, hold_ack=1.
  - hold_req=0 -> IDLE with hold_ack deasserting at the same edge.
- hold_req during SETUP/STROBE/RECOVER: the transaction completes normally; HOLD is entered from IDLE one cycle after RECOVER.
- Latency: after accepting edge E0, rsp_valid is high in the cycle following edge E0+WAIT_STATES+2, and req_ready is high again after edge E0+WAIT_STATES+3.
- Throughput: one access per WAIT_STATES+4 cycles; the core never stalls within a cycle.
- req_valid deasserted while not ready: ignored, no latching.
- Request inputs are sampled only at the accepting edge; later changes do not affect the transaction in flight.
- Reset mid-transaction: strobes and output enables drop asynchronously, the transaction is discarded with no rsp_valid, and the controller is in IDLE at reset release.
- All outputs except req_ready are registered.

Test Plan:
- WAIT_STATES=1, read 0x1234 with memDataIn=0xA5 -> memAddress=0x1234 from SETUP through RECOVER; memRd high exactly 2 cycles; rsp_valid one cycle with rsp_rdata=0xA5 in the cycle after edge E0+3.
- Write 0xFF40 data 0x91 -> memDataOe high for SETUP+2 strobe cycles+RECOVER (4 cycles); memWr high 2 cycles; memDataOut=0x91; rsp_valid one pulse; rsp_rdata unchanged from previous read.
- req_valid held high with alternating reads 0xC000/0xC001 -> acceptances exactly 5 cycles apart; each rsp_rdata matches memDataIn sampled during its own strobe.
- hold_req raised mid-STROBE -> transaction completes and rsp_valid fires; hold_ack=1 and memAddrOe=0 one cycle after RECOVER; req_ready=0 throughout hold.
- hold_req with simultaneous req_valid in IDLE -> hold wins; when hold_req drops, hold_ack=0 and the request is accepted the following cycle.
- rst_n pulsed low during STROBE -> memRd and memDataOe drop immediately with no rsp_valid; after release req_ready=1.
- WAIT_STATES=0 build -> memRd one cycle; access takes 4 cycles.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns single-byte core requests into external bus cycles
// with setup, strobe, wait-state and recovery phases, plus bus hand-off.
module mem_bus_ctrl #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic [15:0] memAddress,
   output logic        memAddrOe,
   output logic [7:0]  memDataOut,
   input  logic [7:0]  memDataIn,
   output logic        memDataOe,
   output logic        memRd,
   output logic        memWr,
   input  logic        hold_req,
   output logic        hold_ack
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      RECOVER,
      HOLD
   } state_t;

   localparam logic [3:0] STROBE_LOAD = 4'(WAIT_STATES);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        wr_q;
   logic        accept;
   logic        cnt_zero;

   // Next-cycle values of the registered outputs.
   logic        rsp_valid_nxt;
   logic [7:0]  rsp_rdata_nxt;
   logic [15:0] mem_address_nxt;
   logic        mem_addr_oe_nxt;
   logic [7:0]  mem_data_out_nxt;
   logic        mem_data_oe_nxt;
   logic        mem_rd_nxt;
   logic        mem_wr_nxt;
   logic        hold_ack_nxt;
   logic        wr_nxt;
   logic        busy_nxt;

   // A request is only taken in IDLE when nobody else wants the bus.
   assign req_ready = (state == IDLE) && !hold_req;
   assign accept    = req_ready && req_valid;
   assign cnt_zero  = (cnt == 4'd0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; hold has priority over a new request in IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (hold_req) begin
               state_nxt = HOLD;
            end else if (req_valid) begin
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = STROBE;
         end
         STROBE: begin
            if (cnt_zero) begin
               state_nxt = RECOVER;
            end
         end
         RECOVER: begin
            state_nxt = IDLE;
         end
         HOLD: begin
            if (!hold_req) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Transaction direction and strobe-length counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= 1'b0;
         cnt  <= 4'd0;
      end else begin
         if (accept) begin
            wr_q <= req_write;
         end
         if (state == SETUP) begin
            cnt <= STROBE_LOAD;
         end else if ((state == STROBE) && !cnt_zero) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Output decode from the state being entered, so the pins are registered.
   always_comb begin
      wr_nxt           = accept ? req_write : wr_q;
      busy_nxt         = (state_nxt == SETUP)
                      || (state_nxt == STROBE)
                      || (state_nxt == RECOVER);
      mem_address_nxt  = memAddress;
      mem_data_out_nxt = memDataOut;
      rsp_rdata_nxt    = rsp_rdata;
      if (accept) begin
         mem_address_nxt = req_addr;
         if (req_write) begin
            mem_data_out_nxt = req_wdata;
         end
      end
      if ((state == STROBE) && cnt_zero && !wr_q) begin
         rsp_rdata_nxt = memDataIn;
      end
      mem_rd_nxt      = (state_nxt == STROBE) && !wr_nxt;
      mem_wr_nxt      = (state_nxt == STROBE) && wr_nxt;
      mem_data_oe_nxt = busy_nxt && wr_nxt;
      rsp_valid_nxt   = (state_nxt == RECOVER);
      hold_ack_nxt    = (state_nxt == HOLD);
      mem_addr_oe_nxt = (state_nxt != HOLD);
   end

   // Output registers; reset drops strobes and enables immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 8'h00;
         memAddress <= 16'h0000;
         memAddrOe  <= 1'b1;
         memDataOut <= 8'h00;
         memDataOe  <= 1'b0;
         memRd      <= 1'b0;
         memWr      <= 1'b0;
         hold_ack   <= 1'b0;
      end else begin
         rsp_valid  <= rsp_valid_nxt;
         rsp_rdata  <= rsp_rdata_nxt;
         memAddress <= mem_address_nxt;
         memAddrOe  <= mem_addr_oe_nxt;
         memDataOut <= mem_data_out_nxt;
         memDataOe  <= mem_data_oe_nxt;
         memRd      <= mem_rd_nxt;
         memWr      <= mem_wr_nxt;
         hold_ack   <= hold_ack_nxt;
      end
   end

endmodule
